cache_entry_ram: RTL and testbench



---
 rtl/cave_mem_pkg.sv | 24 ++
 rtl/mem_clear_seq.sv | 56 +++++
 rtl/cache_entry_ram.sv | 111 +++++++++++
 tb/tb_cache_entry_ram.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/cave_mem_pkg.sv
// Shared types and helpers for the Cave cache entry memories.
// The lane merge is bit-granular, so one helper serves any DATA_WIDTH / MASK_WIDTH pairing.
package cave_mem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } mem_state_t;

    // Widest write mask any instance may use; narrower masks are zero-extended by the caller.
    localparam int unsigned MAX_MASK_WIDTH = 256;

    // Result bit bit_idx of merging new over old, where each mask bit covers lane consecutive bits.
    function automatic logic lane_merge(
        input logic                      old_bit,
        input logic                      new_bit,
        input logic [MAX_MASK_WIDTH-1:0] mask,
        input int unsigned               bit_idx,
        input int unsigned               lane
    );
        return mask[bit_idx / lane] ? new_bit : old_bit;
    endfunction

endpackage

// File: rtl/mem_clear_seq.sv
// Post-reset clear sequencer: walks every entry once, then hands the write port to the user.
module mem_clear_seq
    import cave_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ENTRY = '1;

    mem_state_t            state_reg, state_next;
    logic [ADDR_WIDTH-1:0] cnt_reg, cnt_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= CLEAR;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        clr_we     = 1'b0;
        busy       = reset;
        case (state_reg)
            CLEAR: begin
                busy   = 1'b1;
                clr_we = !reset;
                // Stop on the last entry instead of wrapping the counter.
                if (cnt_reg == LAST_ENTRY) begin
                    state_next = READY;
                end else begin
                    cnt_next = cnt_reg + ADDR_WIDTH'(1);
                end
            end
            READY: begin
                state_next = READY;
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    assign clr_addr = cnt_reg;

endmodule

// File: rtl/cache_entry_ram.sv
// Simple dual-port cache entry RAM with lane write masks, optional same-address
// read forwarding and a self-clearing sequence after every reset.
module cache_entry_ram
    import cave_mem_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 2,
    parameter int                    DATA_WIDTH  = 87,
    parameter int                    MASK_WIDTH  = 1,
    parameter int                    BYPASS      = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic                  wr_en,
    input  logic [MASK_WIDTH-1:0] wr_mask,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy
);

    localparam int          DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned LANE  = DATA_WIDTH / MASK_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;

    mem_clear_seq #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clear_seq (
        .clock    (clock),
        .reset    (reset),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // busy already covers reset, so nothing from the user port lands while clearing.
    logic user_wr;
    logic user_rd;
    assign user_wr = wr_en && !busy;
    assign user_rd = rd_en && !busy;

    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [MASK_WIDTH-1:0] wmask;
    logic [DATA_WIDTH-1:0] wdata;

    always_comb begin
        we    = user_wr;
        waddr = wr_addr;
        wmask = wr_mask;
        wdata = wr_data;
        if (clr_we) begin
            we    = 1'b1;
            waddr = clr_addr;
            wmask = '1;
            wdata = CLEAR_VALUE;
        end
    end

    always_ff @(posedge clock) begin
        if (we) begin
            for (int i = 0; i < MASK_WIDTH; i++) begin
                if (wmask[i]) begin
                    mem[waddr][i*LANE +: LANE] <= wdata[i*LANE +: LANE];
                end
            end
        end
    end

    logic [DATA_WIDTH-1:0] read_word;

    generate
        if (BYPASS != 0) begin : g_bypass
            logic [DATA_WIDTH-1:0] stored_word;
            logic [DATA_WIDTH-1:0] fwd_word;
            logic                  collide;

            assign stored_word = mem[rd_addr];
            assign collide     = user_wr && (wr_addr == rd_addr);

            for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit
                assign fwd_word[gi] = lane_merge(stored_word[gi], wr_data[gi],
                                                 MAX_MASK_WIDTH'(wr_mask), gi, LANE);
            end

            assign read_word = collide ? fwd_word : stored_word;
        end else begin : g_no_bypass
            assign read_word = mem[rd_addr];
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= user_rd;
            if (user_rd) begin
                rd_data <= read_word;
            end
        end
    end

endmodule

// File: tb/tb_cache_entry_ram.sv
// Bench for cache_entry_ram: forwarding and non-forwarding instances driven in lockstep
// through a directed vector table, reset sequences and a randomized model-checked run.
module tb_cache_entry_ram;

    localparam int DW = 87;
    localparam logic [DW-1:0] CV   = 87'h5A;
    localparam logic [DW-1:0] ONES = '1;
    localparam logic [DW-1:0] M1   = ~{29'h0, 29'h1FFF_FFFF, 29'h0};

    logic          clock;
    logic          reset;
    logic [1:0]    rd_addr;
    logic          rd_en;
    logic [1:0]    wr_addr;
    logic          wr_en;
    logic [2:0]    wr_mask;
    logic [DW-1:0] wr_data;

    logic [DW-1:0] rd_data_b, rd_data_n;
    logic          rd_valid_b, rd_valid_n;
    logic          busy_b, busy_n;

    cache_entry_ram #(
        .ADDR_WIDTH (2), .DATA_WIDTH (DW), .MASK_WIDTH (3), .BYPASS (1), .CLEAR_VALUE (CV)
    ) u_byp (
        .clock (clock), .reset (reset),
        .rd_addr (rd_addr), .rd_en (rd_en), .rd_data (rd_data_b), .rd_valid (rd_valid_b),
        .wr_addr (wr_addr), .wr_en (wr_en), .wr_mask (wr_mask), .wr_data (wr_data),
        .busy (busy_b)
    );

    cache_entry_ram #(
        .ADDR_WIDTH (2), .DATA_WIDTH (DW), .MASK_WIDTH (3), .BYPASS (0), .CLEAR_VALUE (CV)
    ) u_nob (
        .clock (clock), .reset (reset),
        .rd_addr (rd_addr), .rd_en (rd_en), .rd_data (rd_data_n), .rd_valid (rd_valid_n),
        .wr_addr (wr_addr), .wr_en (wr_en), .wr_mask (wr_mask), .wr_data (wr_data),
        .busy (busy_n)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic          rst;
        logic          re;
        logic [1:0]    ra;
        logic          we;
        logic [1:0]    wa;
        logic [2:0]    wm;
        logic [DW-1:0] wd;
        logic          eb;
        logic          ev;
        logic [DW-1:0] ed1;
        logic [DW-1:0] ed0;
    } vec_t;

    int            n_cmp  = 0;
    int            n_fail = 0;
    logic [DW-1:0] last_d1, last_d0;
    logic [DW-1:0] mdl [4];
    vec_t          tbl [$];

    function automatic vec_t mk(logic rst, logic re, logic [1:0] ra, logic we, logic [1:0] wa,
                                logic [2:0] wm, logic [DW-1:0] wd, logic eb, logic ev,
                                logic [DW-1:0] ed1, logic [DW-1:0] ed0);
        vec_t v;
        v.rst = rst; v.re = re; v.ra = ra; v.we = we; v.wa = wa; v.wm = wm; v.wd = wd;
        v.eb = eb; v.ev = ev; v.ed1 = ed1; v.ed0 = ed0;
        return v;
    endfunction

    task automatic check(input string tag, input string what, input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s %s: got %h expected %h", tag, what, got, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic rst, input logic re, input logic [1:0] ra,
                       input logic we, input logic [1:0] wa, input logic [2:0] wm,
                       input logic [DW-1:0] wd, input logic eb, input logic ev,
                       input logic [DW-1:0] ed1, input logic [DW-1:0] ed0);
        reset   = rst;
        rd_en   = re;
        rd_addr = ra;
        wr_en   = we;
        wr_addr = wa;
        wr_mask = wm;
        wr_data = wd;
        @(posedge clock);
        #1;
        check(tag, "busy_byp",      DW'(busy_b),     DW'(eb));
        check(tag, "busy_nobyp",    DW'(busy_n),     DW'(eb));
        check(tag, "rd_valid_byp",  DW'(rd_valid_b), DW'(ev));
        check(tag, "rd_valid_nobyp",DW'(rd_valid_n), DW'(ev));
        check(tag, "rd_data_byp",   rd_data_b,       ed1);
        check(tag, "rd_data_nobyp", rd_data_n,       ed0);
        last_d1 = ed1;
        last_d0 = ed0;
        $display("%s rst=%b rd=%b@%0d wr=%b@%0d m=%b busy=%b vld=%b data=%h/%h",
                 tag, rst, re, ra, we, wa, wm, busy_b, rd_valid_b, rd_data_b, rd_data_n);
        @(negedge clock);
    endtask

    initial begin
        logic          re, we;
        logic [1:0]    ra, wa;
        logic [2:0]    wm;
        logic [DW-1:0] wd, old, emask, e1, e0;
        logic [22:0]   hi;

        reset = 1'b1; rd_en = 1'b0; rd_addr = '0; wr_en = 1'b0;
        wr_addr = '0; wr_mask = '0; wr_data = '0;
        last_d1 = '0; last_d0 = '0;

        // Reset, clear with requests attempted while busy, then directed traffic.
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 0, 0, 0, 0, 0, '0, 1, 0, '0, '0));
        tbl.push_back(mk(0, 1, 1, 1, 1, 3'b111, ONES, 1, 0, '0, '0));
        tbl.push_back(mk(0, 1, 2, 1, 2, 3'b111, ONES, 1, 0, '0, '0));
        tbl.push_back(mk(0, 1, 3, 1, 3, 3'b111, ONES, 1, 0, '0, '0));
        tbl.push_back(mk(0, 1, 1, 1, 1, 3'b111, ONES, 0, 0, '0, '0));
        for (int a = 0; a < 4; a++) tbl.push_back(mk(0, 1, 2'(a), 0, 0, 0, '0, 0, 1, CV, CV));
        tbl.push_back(mk(0, 0, 0, 1, 2, 3'b111, 87'h123, 0, 0, CV, CV));
        tbl.push_back(mk(0, 1, 2, 0, 0, 0, '0, 0, 1, 87'h123, 87'h123));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, '0, 0, 0, 87'h123, 87'h123));
        tbl.push_back(mk(0, 0, 0, 1, 1, 3'b111, ONES, 0, 0, 87'h123, 87'h123));
        tbl.push_back(mk(0, 0, 0, 1, 1, 3'b010, '0, 0, 0, 87'h123, 87'h123));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, '0, 0, 1, M1, M1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 3'b111, 87'hAA, 0, 0, M1, M1));
        tbl.push_back(mk(0, 1, 0, 1, 0, 3'b111, 87'hBB, 0, 1, 87'hBB, 87'hAA));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, '0, 0, 1, 87'hBB, 87'hBB));
        tbl.push_back(mk(0, 1, 0, 1, 0, 3'b001, ONES, 0, 1, 87'h1FFF_FFFF, 87'hBB));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, '0, 0, 1, 87'h1FFF_FFFF, 87'h1FFF_FFFF));
        tbl.push_back(mk(0, 1, 2, 1, 3, 3'b111, 87'h777, 0, 1, 87'h123, 87'h123));
        tbl.push_back(mk(0, 1, 3, 0, 0, 0, '0, 0, 1, 87'h777, 87'h777));
        tbl.push_back(mk(0, 1, 3, 1, 3, 3'b000, '0, 0, 1, 87'h777, 87'h777));
        tbl.push_back(mk(0, 1, 3, 0, 0, 0, '0, 0, 1, 87'h777, 87'h777));

        for (int i = 0; i < tbl.size(); i++) begin
            cyc($sformatf("vec%0d", i), tbl[i].rst, tbl[i].re, tbl[i].ra, tbl[i].we, tbl[i].wa,
                tbl[i].wm, tbl[i].wd, tbl[i].eb, tbl[i].ev, tbl[i].ed1, tbl[i].ed0);
        end

        // Reset with a read in flight, then a second reset when the clear counter reaches 2.
        cyc("rst_inflight", 1, 1, 3, 0, 0, 0, '0, 1, 0, '0, '0);
        cyc("clr_a0",       0, 1, 0, 0, 0, 0, '0, 1, 0, '0, '0);
        cyc("clr_a1",       0, 1, 1, 0, 0, 0, '0, 1, 0, '0, '0);
        cyc("rst_cnt2",     1, 1, 2, 0, 0, 0, '0, 1, 0, '0, '0);
        cyc("clr_b0",       0, 1, 0, 1, 2, 3'b111, '0, 1, 0, '0, '0);
        cyc("clr_b1",       0, 0, 0, 0, 0, 0, '0, 1, 0, '0, '0);
        cyc("clr_b2",       0, 1, 1, 1, 1, 3'b111, '0, 1, 0, '0, '0);
        cyc("clr_b3",       0, 1, 1, 1, 1, 3'b111, '0, 0, 0, '0, '0);
        for (int a = 0; a < 4; a++)
            cyc($sformatf("post_clr_rd%0d", a), 0, 1, 2'(a), 0, 0, 0, '0, 0, 1, CV, CV);

        // Randomized traffic against a word-level model of the entries.
        for (int a = 0; a < 4; a++) mdl[a] = CV;
        for (int k = 0; k < 400; k++) begin
            re = ($urandom_range(0, 9) < 7);
            we = ($urandom_range(0, 1) == 1);
            ra = 2'($urandom);
            wa = ($urandom_range(0, 3) == 0) ? ra : 2'($urandom);
            wm = 3'($urandom);
            hi = 23'($urandom);
            wd = {hi, 32'($urandom), 32'($urandom)};
            emask = {{29{wm[2]}}, {29{wm[1]}}, {29{wm[0]}}};
            old = mdl[ra];
            if (re) begin
                e0 = old;
                e1 = (we && wa == ra) ? ((old & ~emask) | (wd & emask)) : old;
            end else begin
                e1 = last_d1;
                e0 = last_d0;
            end
            if (we) mdl[wa] = (mdl[wa] & ~emask) | (wd & emask);
            cyc($sformatf("rand%0d", k), 0, re, ra, we, wa, wm, wd, 0, re, e1, e0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
